// File: rtl/zap_bp_pkg.sv
// Shared types and constants for the 2-bit counter branch predictor.
package zap_bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_e;

    typedef enum logic [1:0] {
        BST_NONE  = 2'b00,
        BST_NT    = 2'b01,
        BST_TAKEN = 2'b10,
        BST_RSVD  = 2'b11
    } bstate_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    typedef enum logic [1:0] {
        WOP_SET_SNT = 2'd0,
        WOP_INC     = 2'd1,
        WOP_DEC     = 2'd2
    } wr_op_e;

    typedef struct packed {
        logic [31:0] inst;
        logic        val;
        logic        abt;
        logic [31:0] pc_plus_8;
    } fetch_bundle_t;

    localparam logic [31:0] CLR_INST      = 32'd0;
    localparam logic        CLR_VAL       = 1'b0;
    localparam logic        CLR_ABT       = 1'b0;
    localparam logic [31:0] CLR_PC_PLUS_8 = 32'd8;

    localparam fetch_bundle_t CLR_BUNDLE = '{
        inst:      CLR_INST,
        val:       CLR_VAL,
        abt:       CLR_ABT,
        pc_plus_8: CLR_PC_PLUS_8
    };

    // Saturating counter update applied by the table write port.
    function automatic ctr_e ctr_update(input ctr_e cur, input wr_op_e op);
        ctr_e nxt;
        nxt = cur;
        case (op)
            WOP_SET_SNT: nxt = CTR_SNT;
            WOP_INC:     if (cur != CTR_ST)  nxt = ctr_e'(2'(cur) + 2'd1);
            WOP_DEC:     if (cur != CTR_SNT) nxt = ctr_e'(2'(cur) - 2'd1);
            default:     nxt = cur;
        endcase
        return nxt;
    endfunction

    function automatic bstate_e ctr_to_bstate(input ctr_e c);
        return c[1] ? BST_TAKEN : BST_NT;
    endfunction

endpackage

// File: rtl/zap_bp_counter_ram.sv
// Counter table: one combinational read port, one read-modify-write port.
// The read port sees the pre-write contents of an entry written this cycle.
module zap_bp_counter_ram
    import zap_bp_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned IDX_W = 9
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] raddr_i,
    output ctr_e             rdata_c_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  wr_op_e           wop_i
);

    ctr_e mem_q [DEPTH];

    assign rdata_c_o = mem_q[raddr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= ctr_update(mem_q[waddr_i], wop_i);
        end
    end

endmodule

// File: rtl/zap_branch_predict_param.sv
// Bimodal 2-bit branch predictor with registered fetch bundle and table-clear walk.
// Optional gshare indexing is enabled by defining ZAP_BP_GSHARE_EN.
module zap_branch_predict_param
    import zap_bp_pkg::*;
#(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned HIST_W = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_stall_from_issue,
    input  logic        i_stall_from_decode,
    input  logic        i_clear_from_decode,
    input  logic        i_confirm_from_alu,
    input  logic [31:0] i_pc_from_alu,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic        i_val,
    input  logic        i_abt,
    input  logic [31:0] i_pc_plus_8,
    output logic [31:0] o_inst_ff,
    output logic        o_val_ff,
    output logic        o_abt_ff,
    output logic [31:0] o_pc_plus_8_ff,
    output logic [1:0]  o_bstate_ff,
    output logic        o_init_busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    fetch_bundle_t    bundle_q, bundle_d;
    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] walk_q, walk_d;
    logic             busy_q, busy_d;
    bstate_e          bstate_q, bstate_d;

    logic [IDX_W-1:0] lkp_idx_c;
    logic [IDX_W-1:0] upd_idx_c;
    ctr_e             rd_ctr_c;
    logic             we_c;
    logic [IDX_W-1:0] waddr_c;
    wr_op_e           wop_c;
    logic             upd_en_c;

    assign upd_en_c = (state_q == ST_RUN) && (i_clear_from_alu || i_confirm_from_alu);

`ifdef ZAP_BP_GSHARE_EN
    logic [HIST_W-1:0] hist_q, hist_d;

    assign lkp_idx_c = i_pc[IDX_W:1]          ^ IDX_W'(hist_q);
    assign upd_idx_c = i_pc_from_alu[IDX_W:1] ^ IDX_W'(hist_q);

    // Outcome shifts in after the write, so this cycle's update used pre-shift history.
    always_comb begin
        hist_d = hist_q;
        if (upd_en_c) begin
            hist_d = HIST_W'({hist_q, i_clear_from_alu});
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    localparam int unsigned unused_hist_w = HIST_W;

    assign lkp_idx_c = i_pc[IDX_W:1];
    assign upd_idx_c = i_pc_from_alu[IDX_W:1];
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_pc[31:IDX_W+1], i_pc[0],
                              i_pc_from_alu[31:IDX_W+1], i_pc_from_alu[0]};

    zap_bp_counter_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk_i     (i_clk),
        .raddr_i   (lkp_idx_c),
        .rdata_c_o (rd_ctr_c),
        .we_i      (we_c),
        .waddr_i   (waddr_c),
        .wop_i     (wop_c)
    );

    // Table-clear walk followed by normal ALU-driven training.
    always_comb begin
        state_d = state_q;
        walk_d  = walk_q;
        we_c    = 1'b0;
        waddr_c = upd_idx_c;
        wop_c   = i_clear_from_alu ? WOP_INC : WOP_DEC;
        case (state_q)
            ST_INIT: begin
                we_c    = !i_reset;
                waddr_c = walk_q;
                wop_c   = WOP_SET_SNT;
                walk_d  = walk_q + IDX_W'(1);
                if (walk_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                we_c = upd_en_c && !i_reset;
            end
            default: state_d = ST_INIT;
        endcase
        busy_d   = (state_d == ST_INIT);
        bstate_d = (state_q == ST_RUN) ? ctr_to_bstate(rd_ctr_c) : BST_NONE;
    end

    // Fetch bundle priority: writeback clear, data stall, ALU clear, stalls, decode clear.
    always_comb begin
        bundle_d = bundle_q;
        if (i_clear_from_writeback) begin
            bundle_d = CLR_BUNDLE;
        end else if (i_data_stall) begin
            bundle_d = bundle_q;
        end else if (i_clear_from_alu) begin
            bundle_d = CLR_BUNDLE;
        end else if (i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode) begin
            bundle_d = bundle_q;
        end else if (i_clear_from_decode) begin
            bundle_d = CLR_BUNDLE;
        end else begin
            bundle_d = '{inst: i_inst, val: i_val, abt: i_abt, pc_plus_8: i_pc_plus_8};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bundle_q <= CLR_BUNDLE;
            state_q  <= ST_INIT;
            walk_q   <= '0;
            busy_q   <= 1'b1;
            bstate_q <= BST_NONE;
        end else begin
            bundle_q <= bundle_d;
            state_q  <= state_d;
            walk_q   <= walk_d;
            busy_q   <= busy_d;
            bstate_q <= bstate_d;
        end
    end

    assign o_inst_ff      = bundle_q.inst;
    assign o_val_ff       = bundle_q.val;
    assign o_abt_ff       = bundle_q.abt;
    assign o_pc_plus_8_ff = bundle_q.pc_plus_8;
    assign o_bstate_ff    = 2'(bstate_q);
    assign o_init_busy    = busy_q;

endmodule

// File: tb/tb_zap_branch_predict_param.sv
// Directed self-checking bench for zap_branch_predict_param (default DEPTH 512).
module tb_zap_branch_predict_param;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_clear_from_writeback, i_data_stall, i_clear_from_alu;
    logic        i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode;
    logic        i_clear_from_decode, i_confirm_from_alu;
    logic [31:0] i_pc_from_alu, i_pc, i_inst, i_pc_plus_8;
    logic        i_val, i_abt;
    logic [31:0] o_inst_ff, o_pc_plus_8_ff;
    logic        o_val_ff, o_abt_ff, o_init_busy;
    logic [1:0]  o_bstate_ff;

    int n_checks = 0;
    int n_fail   = 0;

    zap_branch_predict_param dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_clear_from_writeback (i_clear_from_writeback),
        .i_data_stall           (i_data_stall),
        .i_clear_from_alu       (i_clear_from_alu),
        .i_stall_from_shifter   (i_stall_from_shifter),
        .i_stall_from_issue     (i_stall_from_issue),
        .i_stall_from_decode    (i_stall_from_decode),
        .i_clear_from_decode    (i_clear_from_decode),
        .i_confirm_from_alu     (i_confirm_from_alu),
        .i_pc_from_alu          (i_pc_from_alu),
        .i_pc                   (i_pc),
        .i_inst                 (i_inst),
        .i_val                  (i_val),
        .i_abt                  (i_abt),
        .i_pc_plus_8            (i_pc_plus_8),
        .o_inst_ff              (o_inst_ff),
        .o_val_ff               (o_val_ff),
        .o_abt_ff               (o_abt_ff),
        .o_pc_plus_8_ff         (o_pc_plus_8_ff),
        .o_bstate_ff            (o_bstate_ff),
        .o_init_busy            (o_init_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_ctrl();
        i_clear_from_writeback = 1'b0; i_data_stall        = 1'b0;
        i_clear_from_alu       = 1'b0; i_stall_from_shifter = 1'b0;
        i_stall_from_issue     = 1'b0; i_stall_from_decode  = 1'b0;
        i_clear_from_decode    = 1'b0; i_confirm_from_alu   = 1'b0;
    endtask

    // Counts cycles with o_init_busy high, bounded so a stuck DUT still ends.
    task automatic run_init(output int cycles);
        cycles = 0;
        while (o_init_busy === 1'b1 && cycles < 2000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        int n;
        i_reset = 1'b1;
        i_inst = 32'hCAFE_F00D; i_val = 1'b1; i_abt = 1'b1; i_pc_plus_8 = 32'h0000_4008;
        i_clear_from_alu = 1'b1; i_pc_from_alu = 32'h300; i_pc = 32'h300;
        tick(); tick();
        n_checks++; if (o_init_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy got %b exp 1", o_init_busy); end
        n_checks++; if (o_bstate_ff !== 2'b00) begin n_fail++; $display("FAIL rst_bstate got %b exp 00", o_bstate_ff); end
        n_checks++; if (o_inst_ff !== 32'h0) begin n_fail++; $display("FAIL rst_inst got %h exp 0", o_inst_ff); end
        n_checks++; if (o_val_ff !== 1'b0 || o_abt_ff !== 1'b0) begin n_fail++; $display("FAIL rst_val_abt got %b%b exp 00", o_val_ff, o_abt_ff); end
        n_checks++; if (o_pc_plus_8_ff !== 32'd8) begin n_fail++; $display("FAIL rst_pc8 got %h exp 8", o_pc_plus_8_ff); end
        i_reset = 1'b0;
        // ALU clear held through INIT must be ignored.
        run_init(n);
        i_clear_from_alu = 1'b0;
        n_checks++; if (n !== 512) begin n_fail++; $display("FAIL init_len got %0d exp 512", n); end
        n_checks++; if (o_bstate_ff !== 2'b00) begin n_fail++; $display("FAIL init_end_bstate got %b exp 00", o_bstate_ff); end
        tick();
        n_checks++; if (o_bstate_ff !== 2'b01) begin n_fail++; $display("FAIL init_drop got %b exp 01", o_bstate_ff); end
        i_pc = 32'h7FC;
        tick();
        n_checks++; if (o_bstate_ff !== 2'b01) begin n_fail++; $display("FAIL post_init got %b exp 01", o_bstate_ff); end
    endtask

    task automatic test_taken();
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10; exp_seq[3] = 2'b10;
        i_pc = 32'h100; i_pc_from_alu = 32'h100;
        for (int k = 0; k < 4; k++) begin
            i_clear_from_alu = (k < 3);
            tick();
            n_checks++; if (o_bstate_ff !== exp_seq[k]) begin n_fail++; $display("FAIL taken_step%0d got %b exp %b", k, o_bstate_ff, exp_seq[k]); end
        end
        i_clear_from_alu = 1'b0;
        i_pc = 32'h104;
        tick();
        n_checks++; if (o_bstate_ff !== 2'b01) begin n_fail++; $display("FAIL neighbour got %b exp 01", o_bstate_ff); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_seq [6];
        exp_seq[0] = 2'b10; exp_seq[1] = 2'b10; exp_seq[2] = 2'b10;
        exp_seq[3] = 2'b01; exp_seq[4] = 2'b01; exp_seq[5] = 2'b01;
        i_pc = 32'h100; i_pc_from_alu = 32'h100;
        // One extra clear at ST, then five confirms.
        for (int k = 0; k < 6; k++) begin
            i_clear_from_alu   = (k == 0);
            i_confirm_from_alu = (k != 0);
            tick();
            n_checks++; if (o_bstate_ff !== exp_seq[k]) begin n_fail++; $display("FAIL sat_step%0d got %b exp %b", k, o_bstate_ff, exp_seq[k]); end
        end
        idle_ctrl();
        tick();
        n_checks++; if (o_bstate_ff !== 2'b01) begin n_fail++; $display("FAIL sat_final got %b exp 01", o_bstate_ff); end
    endtask

    task automatic test_both();
        i_pc = 32'h200; i_pc_from_alu = 32'h200;
        i_clear_from_alu = 1'b1;
        tick();
        i_confirm_from_alu = 1'b1;
        tick();
        idle_ctrl();
        tick();
        n_checks++; if (o_bstate_ff !== 2'b10) begin n_fail++; $display("FAIL both_wins got %b exp 10", o_bstate_ff); end
    endtask

    task automatic test_bundle();
        idle_ctrl();
        i_inst = 32'hDEAD_BEEF; i_val = 1'b1; i_abt = 1'b1; i_pc_plus_8 = 32'h1008;
        tick();
        n_checks++; if (o_inst_ff !== 32'hDEAD_BEEF || o_pc_plus_8_ff !== 32'h1008) begin n_fail++; $display("FAIL load got %h/%h exp deadbeef/1008", o_inst_ff, o_pc_plus_8_ff); end
        n_checks++; if (o_val_ff !== 1'b1 || o_abt_ff !== 1'b1) begin n_fail++; $display("FAIL load_flags got %b%b exp 11", o_val_ff, o_abt_ff); end
        i_inst = 32'h1234_5678; i_val = 1'b0; i_abt = 1'b0; i_pc_plus_8 = 32'h2008;
        i_data_stall = 1'b1; i_clear_from_alu = 1'b1; i_pc_from_alu = 32'h300; i_pc = 32'h300;
        tick(); tick();
        n_checks++; if (o_inst_ff !== 32'hDEAD_BEEF || o_val_ff !== 1'b1) begin n_fail++; $display("FAIL dstall_hold got %h/%b exp deadbeef/1", o_inst_ff, o_val_ff); end
        n_checks++; if (o_bstate_ff !== 2'b01) begin n_fail++; $display("FAIL dstall_rdfirst got %b exp 01", o_bstate_ff); end
        idle_ctrl();
        tick();
        n_checks++; if (o_bstate_ff !== 2'b10) begin n_fail++; $display("FAIL dstall_update got %b exp 10", o_bstate_ff); end
        n_checks++; if (o_inst_ff !== 32'h1234_5678) begin n_fail++; $display("FAIL reload got %h exp 12345678", o_inst_ff); end
        i_inst = 32'hDEAD_BEEF; i_val = 1'b1;
        i_stall_from_issue = 1'b1; i_clear_from_decode = 1'b1;
        tick();
        n_checks++; if (o_inst_ff !== 32'h1234_5678) begin n_fail++; $display("FAIL stall_over_dclr got %h exp 12345678", o_inst_ff); end
        i_stall_from_issue = 1'b0;
        tick();
        n_checks++; if (o_inst_ff !== 32'h0 || o_pc_plus_8_ff !== 32'd8) begin n_fail++; $display("FAIL dec_clear got %h/%h exp 0/8", o_inst_ff, o_pc_plus_8_ff); end
        idle_ctrl();
        tick();
        i_clear_from_writeback = 1'b1; i_data_stall = 1'b1;
        tick();
        n_checks++; if (o_val_ff !== 1'b0 || o_pc_plus_8_ff !== 32'd8) begin n_fail++; $display("FAIL wb_clear got %b/%h exp 0/8", o_val_ff, o_pc_plus_8_ff); end
        idle_ctrl();
    endtask

    task automatic test_restart();
        int n;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        repeat (100) tick();
        n_checks++; if (o_init_busy !== 1'b1) begin n_fail++; $display("FAIL mid_init_busy got %b exp 1", o_init_busy); end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        run_init(n);
        n_checks++; if (n !== 512) begin n_fail++; $display("FAIL restart_len got %0d exp 512", n); end
        i_pc = 32'h200;
        tick(); tick();
        n_checks++; if (o_bstate_ff !== 2'b01) begin n_fail++; $display("FAIL restart_clr got %b exp 01", o_bstate_ff); end
    endtask

`ifdef ZAP_BP_GSHARE_EN
    task automatic test_gshare();
        i_clear_from_alu = 1'b1;
        i_pc_from_alu = 32'h000;
        tick();
        i_pc_from_alu = 32'h002;
        tick();
        idle_ctrl();
        i_pc = 32'h006;
        tick();
        n_checks++; if (o_bstate_ff !== 2'b10) begin n_fail++; $display("FAIL gshare_idx0 got %b exp 10", o_bstate_ff); end
        i_pc = 32'h002;
        tick();
        n_checks++; if (o_bstate_ff !== 2'b01) begin n_fail++; $display("FAIL gshare_idx2 got %b exp 01", o_bstate_ff); end
    endtask
`endif

    initial begin
        idle_ctrl();
        i_reset = 1'b1;
        i_pc = '0; i_pc_from_alu = '0; i_inst = '0; i_pc_plus_8 = '0;
        i_val = 1'b0; i_abt = 1'b0;
        test_reset();
`ifdef ZAP_BP_GSHARE_EN
        test_restart();
        test_gshare();
`else
        test_taken();
        test_saturate();
        test_both();
        test_bundle();
        test_restart();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
